// File: rtl/cpu_fetch.sv
// Instruction-fetch stage of the moxie pipeline core.
// Pulls 16-bit halfwords over a single-outstanding Wishbone read port and
// assembles short (opcode only) or long (opcode + 32-bit operand) instructions
// for decode. Branches from execute redirect fetch. Stalls hold the
// presented instruction.
//
// state   | meaning
// F_OP    | requesting the opcode halfword at pc
// F_HI    | requesting operand[31:16] at pc+2
// F_LO    | requesting operand[15:0] at pc+4
// PRESENT | instruction valid toward decode, waiting for it to be consumed
module cpu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00001000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        stall_i,
    input  logic [15:0] imem_data_i,
    input  logic        imem_ack_i,
    output logic [31:0] imem_address_o,
    output logic        imem_stb_o,
    output logic        imem_cyc_o,
    output logic [1:0]  imem_sel_o,
    output logic [15:0] opcode,
    output logic [31:0] operand,
    output logic        valid,
    output logic [31:0] PC_o
);

    typedef enum logic [1:0] {F_OP, F_HI, F_LO, PRESENT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        stb_q, stb_d;
    logic        valid_q, valid_d;
    logic [15:0] opcode_q, opcode_d;
    logic [31:0] operand_q, operand_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] addr_off;

    function automatic logic is_long(input logic [15:0] op);
        logic hit;
        case (op[14:8])
            7'h01, 7'h03, 7'h08, 7'h09, 7'h0C, 7'h0D, 7'h1A, 7'h1B, 7'h1D,
            7'h1F, 7'h20, 7'h22, 7'h24, 7'h36, 7'h37, 7'h38, 7'h39: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit && !op[15];
    endfunction

    // Bus address follows the halfword the current fetch state is after.
    always_comb begin
        addr_off = 32'd0;
        case (state_q)
            F_HI:    addr_off = 32'd2;
            F_LO:    addr_off = 32'd4;
            default: addr_off = 32'd0;
        endcase
    end

    assign imem_address_o = {pc_q[31:1] + addr_off[31:1], 1'b0};
    assign imem_stb_o     = stb_q;
    assign imem_cyc_o     = stb_q;
    assign imem_sel_o     = stb_q ? 2'b11 : 2'b00;
    assign opcode         = opcode_q;
    assign operand        = operand_q;
    assign valid          = valid_q;
    assign PC_o           = pc_out_q;

    // Next-state logic: bus handshake, instruction assembly, consume, redirect.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        stb_d     = stb_q;
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        pc_out_d  = pc_out_q;

        if (branch_flag_i) begin
            // A coincident ack is dropped: captured fields keep their old values.
            state_d = F_OP;
            pc_d    = {branch_target_i[31:1], 1'b0};
            stb_d   = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                F_OP, F_HI, F_LO: begin
                    if (!stb_q) begin
                        // Strobe is low for at least one cycle between requests.
                        stb_d = 1'b1;
                    end else if (imem_ack_i) begin
                        stb_d = 1'b0;
                        case (state_q)
                            F_OP: begin
                                opcode_d = imem_data_i;
                                if (is_long(imem_data_i)) begin
                                    state_d = F_HI;
                                end else begin
                                    operand_d = 32'd0;
                                    pc_out_d  = pc_q;
                                    valid_d   = 1'b1;
                                    state_d   = PRESENT;
                                end
                            end
                            F_HI: begin
                                operand_d[31:16] = imem_data_i;
                                state_d          = F_LO;
                            end
                            default: begin
                                operand_d[15:0] = imem_data_i;
                                pc_out_d        = pc_q;
                                valid_d         = 1'b1;
                                state_d         = PRESENT;
                            end
                        endcase
                    end
                end
                default: begin
                    if (!stall_i) begin
                        valid_d = 1'b0;
                        pc_d    = pc_q + (is_long(opcode_q) ? 32'd6 : 32'd2);
                        state_d = F_OP;
                    end
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= F_OP;
            pc_q      <= {RESET_PC[31:1], 1'b0};
            stb_q     <= 1'b0;
            valid_q   <= 1'b0;
            opcode_q  <= 16'd0;
            operand_q <= 32'd0;
            pc_out_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            stb_q     <= stb_d;
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            pc_out_q  <= pc_out_d;
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: a Wishbone memory with programmable wait states and a
// transaction-level model of the fetch stage that predicts, each cycle, the
// bus request, the valid flag and the presented instruction.
module tb_cpu_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = 32'd0;
    logic        stall_i = 1'b0;
    logic [15:0] imem_data_i;
    logic        imem_ack_i;
    logic [31:0] imem_address_o;
    logic        imem_stb_o;
    logic        imem_cyc_o;
    logic [1:0]  imem_sel_o;
    logic [15:0] opcode;
    logic [31:0] operand;
    logic        valid;
    logic [31:0] PC_o;

    cpu_fetch #(.RESET_PC(32'h00001000)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .stall_i(stall_i), .imem_data_i(imem_data_i), .imem_ack_i(imem_ack_i),
        .imem_address_o(imem_address_o), .imem_stb_o(imem_stb_o),
        .imem_cyc_o(imem_cyc_o), .imem_sel_o(imem_sel_o),
        .opcode(opcode), .operand(operand), .valid(valid), .PC_o(PC_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory: 8K halfwords aliased over the address space, ack after wait_n waits.
    logic [15:0] mem [0:8191];
    int unsigned wcnt = 0;
    int unsigned wait_n = 0;
    assign imem_data_i = mem[imem_address_o[13:1]];
    assign imem_ack_i  = imem_stb_o && (wcnt >= wait_n);
    always @(posedge clk_i) begin
        if (imem_stb_o && !imem_ack_i) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    int checks = 0;
    int errors = 0;

    // Model of the fetch stage in terms of instructions and bus transfers.
    logic [31:0] m_pc = 32'd0;
    int          m_idx = 0;      // which halfword of the current instruction is being fetched
    logic        m_pres = 1'b0;  // instruction presented to decode
    logic        m_stb = 1'b0;   // a bus request is active this cycle
    logic        m_known = 1'b0;

    function automatic logic [15:0] rd(input logic [31:0] a);
        return mem[a[13:1]];
    endfunction

    function automatic logic long_op(input logic [15:0] op);
        return !op[15] && (op[14:8] inside {7'h01, 7'h03, 7'h08, 7'h09, 7'h0C,
            7'h0D, 7'h1A, 7'h1B, 7'h1D, 7'h1F, 7'h20, 7'h22, 7'h24, 7'h36,
            7'h37, 7'h38, 7'h39});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [15:0] op;
        @(negedge clk_i);
        if (m_known) begin
            op = rd(m_pc);
            chk("stb", 32'(imem_stb_o), 32'(m_stb));
            chk("cyc", 32'(imem_cyc_o), 32'(m_stb));
            chk("sel", 32'(imem_sel_o), m_stb ? 32'd3 : 32'd0);
            chk("valid", 32'(valid), 32'(m_pres));
            if (m_stb) chk("address", imem_address_o, m_pc + 32'(2 * m_idx));
            if (m_pres) begin
                chk("opcode", 32'(opcode), 32'(op));
                chk("operand", operand, long_op(op) ? {rd(m_pc + 32'd2), rd(m_pc + 32'd4)} : 32'd0);
                chk("pc_o", PC_o, m_pc);
            end
        end
        // Predict the cycle after the coming edge.
        if (rst_i) begin
            m_pc = 32'h00001000; m_idx = 0; m_pres = 1'b0; m_stb = 1'b0; m_known = 1'b1;
        end else if (branch_flag_i) begin
            m_pc = {branch_target_i[31:1], 1'b0}; m_idx = 0; m_pres = 1'b0; m_stb = 1'b0;
        end else if (m_pres) begin
            if (!stall_i) begin
                m_pc = m_pc + (long_op(rd(m_pc)) ? 32'd6 : 32'd2);
                m_pres = 1'b0; m_idx = 0;
            end
        end else if (m_stb) begin
            if (imem_ack_i) begin
                m_stb = 1'b0;
                if ((m_idx == 0 && !long_op(rd(m_pc))) || m_idx == 2) m_pres = 1'b1;
                else m_idx++;
            end
        end else begin
            m_stb = 1'b1;
        end
        @(posedge clk_i);
        #1;
    endtask

    logic [6:0] longs [17] = '{7'h01, 7'h03, 7'h08, 7'h09, 7'h0C, 7'h0D, 7'h1A,
        7'h1B, 7'h1D, 7'h1F, 7'h20, 7'h22, 7'h24, 7'h36, 7'h37, 7'h38, 7'h39};

    initial begin
        int n;
        for (int i = 0; i < 8192; i++) begin
            if ($urandom_range(0, 2) == 0) mem[i] = {1'b0, longs[$urandom_range(0, 16)], 8'($urandom)};
            else mem[i] = 16'($urandom);
        end
        mem[13'h0800] = 16'h2634;   // 0x1000 short
        mem[13'h0801] = 16'h0120;   // 0x1002 long
        mem[13'h0802] = 16'hDEAD;
        mem[13'h0803] = 16'hBEEF;
        mem[13'h0804] = 16'h0300;   // 0x1008 long, branched away during F_HI
        mem[13'h1000] = 16'h1234;   // 0x2000 short
        mem[13'h1FFE] = 16'h0100;   // 0xFFFFFFFC long, operand wraps to 0x0

        step(); step();
        rst_i = 1'b0;

        // Zero-wait: short at 0x1000, long at 0x1002, then reach F_HI of 0x1008.
        n = 0;
        while (n < 40 && !(m_stb && m_idx == 1 && m_pc == 32'h00001008)) begin step(); n++; end
        chk("reach_fhi", 32'(m_stb && m_idx == 1 && m_pc == 32'h00001008), 32'd1);
        chk("fhi_ack", 32'(imem_ack_i), 32'd1);
        branch_flag_i = 1'b1; branch_target_i = 32'h00002001;
        step();
        branch_flag_i = 1'b0;

        // Three wait states on the instruction at 0x2000.
        wait_n = 3;
        n = 0;
        while (n < 40 && !m_pres) begin step(); n++; end
        chk("wait_present", 32'(m_pres), 32'd1);
        wait_n = 0;

        // Stall five cycles while presenting, then release.
        stall_i = 1'b1;
        repeat (5) step();
        stall_i = 1'b0;
        step(); step();

        // Reset pulse during an active request.
        n = 0;
        while (n < 40 && !m_stb) begin step(); n++; end
        chk("req_active", 32'(m_stb), 32'd1);
        rst_i = 1'b1; wait_n = 2;
        step();
        rst_i = 1'b0;
        repeat (6) step();
        wait_n = 0;

        // Address wrap on a long instruction at the top of memory.
        branch_flag_i = 1'b1; branch_target_i = 32'hFFFFFFFC;
        step();
        branch_flag_i = 1'b0;
        n = 0;
        while (n < 40 && m_pc != 32'h00000002) begin step(); n++; end
        chk("pc_wrap", m_pc, 32'h00000002);
        repeat (4) step();

        // Randomized traffic.
        repeat (3000) begin
            rst_i           = ($urandom_range(0, 199) == 0);
            branch_flag_i   = ($urandom_range(0, 39) == 0);
            branch_target_i = $urandom;
            stall_i         = ($urandom_range(0, 2) == 0);
            if (!imem_stb_o) wait_n = $urandom_range(0, 3);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
